sim_sequencer: RTL and testbench

SIM_SEQUENCER -- requirements
Module: sim_sequencer

---
 rtl/sim_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_sim_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_sequencer.sv
// sim_sequencer -- simulation harness sequencer for a CPU core.
//
// Purpose:
//   Holds the CPU in reset for RST_CYCLES cycles after RST releases, then lets it
//   run. While it runs, the block counts cycles, optionally inserts periodic RDY
//   stalls, optionally raises IRQ/NMI windows, and ends the run on one of these:
//   - an end-of-program flag,
//   - an opcode fetch from STOP_ADDR,
//   - a cycle limit (MAX_CYCLES).
//   The DONE state is sticky until RST and freezes the CPU with RDY=0.
//
// Optional feature:
//   SIM_SEQ_IRQ_EN -- when defined, the IRQ/NMI scheduler is built. When it is
//   undefined, IRQ and NMI are tied to 0.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   RST        in   synchronous active-high reset
//   sync       in   CPU opcode-fetch strobe
//   AB         in   CPU address bus [AW-1:0]
//   WE         in   CPU write enable (monitored only, affects nothing)
//   onend      in   end-of-program flag from RAM
//   cpu_rst    out  reset to the CPU
//   RDY        out  CPU ready (0 during stalls and once finished)
//   IRQ        out  interrupt request, active-high
//   NMI        out  non-maskable interrupt, active-high
//   cycle_cnt  out  run-cycle count [31:0], saturating
//   done       out  run finished
//   timeout    out  run ended by the MAX_CYCLES limit
//
// All outputs are registered. Each is a function of the next state, so an output
// changes on the same edge as the state transition that explains it.

module sim_sequencer #(
  parameter int unsigned AW         = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned RDY_PERIOD = 0,
  parameter int unsigned RDY_STALL  = 1,
  parameter logic [15:0] STOP_ADDR  = 16'hFFFF,
  parameter int unsigned IRQ_AT     = 0,
  parameter int unsigned IRQ_LEN    = 8,
  parameter int unsigned NMI_AT     = 0,
  parameter int unsigned NMI_LEN    = 2
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          sync,
  input  logic [AW-1:0] AB,
  input  logic          WE,
  input  logic          onend,
  output logic          cpu_rst,
  output logic          RDY,
  output logic          IRQ,
  output logic          NMI,
  output logic [31:0]   cycle_cnt,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] STOP_A      = STOP_ADDR[AW-1:0];
  localparam logic [31:0]   HOLD_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   MAX_LAST    = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]   PERIOD_LAST = 32'(RDY_PERIOD - 1);
  localparam logic [31:0]   STALL_LAST  = 32'(RDY_STALL - 1);
  localparam bit            STALL_EN    = (RDY_PERIOD != 0);

  state_e      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;

  logic        stop_hit;
  logic        limit_hit;
  logic [31:0] cnt_inc;

  // WE is observed by the harness but intentionally drives nothing.
  logic we_unused;
  assign we_unused = WE;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stop_hit  = onend | (sync & (AB == STOP_A));
    limit_hit = (cycle_cnt_q == MAX_LAST);
    // Saturate instead of wrapping.
    cnt_inc   = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 32'd1;

    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    run_cnt_d   = run_cnt_q;
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;

    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end

      RUN: begin
        cycle_cnt_d = cnt_inc;
        // Priority order: stop, then cycle limit, then stall entry.
        if (stop_hit) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (limit_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (STALL_EN) begin
          // Stall spacing counts RUN cycles only. With a period of 4 and a stall
          // of 2, stalls start after cycle_cnt 3, 9, 15, ...
          if (run_cnt_q == PERIOD_LAST) begin
            state_d     = STALL;
            run_cnt_d   = '0;
            stall_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 32'd1;
          end
        end
      end

      STALL: begin
        cycle_cnt_d = cnt_inc;
        if (stop_hit) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (limit_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (stall_cnt_q == STALL_LAST) begin
          state_d = RUN;
        end else begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end

      DONE: begin
        // Sticky until RST. Everything is frozen.
        state_d = DONE;
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    cpu_rst_d = (state_d == HOLD);
    rdy_d     = (state_d == HOLD) || (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
      cycle_cnt_q <= '0;
      cpu_rst_q   <= 1'b1;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      cpu_rst_q   <= cpu_rst_d;
      rdy_q       <= rdy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign RDY       = rdy_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

  // ---------------------------------------------------------------------------
  // Interrupt scheduler
  // ---------------------------------------------------------------------------
`ifdef SIM_SEQ_IRQ_EN
  // Window bounds use 33 bits so that AT+LEN cannot overflow.
  localparam logic [32:0] IRQ_START = 33'(IRQ_AT);
  localparam logic [32:0] IRQ_END   = 33'(IRQ_AT) + 33'(IRQ_LEN);
  localparam logic [32:0] NMI_START = 33'(NMI_AT);
  localparam logic [32:0] NMI_END   = 33'(NMI_AT) + 33'(NMI_LEN);

  logic irq_q, irq_d;
  logic nmi_q, nmi_d;
  logic live;

  always_comb begin
    // Only qualify while running, and never carry an interrupt into DONE.
    live  = ((state_q == RUN) || (state_q == STALL)) &&
            ((state_d == RUN) || (state_d == STALL));
    irq_d = live && (IRQ_AT != 0) &&
            ({1'b0, cycle_cnt_q} >= IRQ_START) && ({1'b0, cycle_cnt_q} < IRQ_END);
    nmi_d = live && (NMI_AT != 0) &&
            ({1'b0, cycle_cnt_q} >= NMI_START) && ({1'b0, cycle_cnt_q} < NMI_END);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      irq_q <= 1'b0;
      nmi_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      nmi_q <= nmi_d;
    end
  end

  assign IRQ = irq_q;
  assign NMI = nmi_q;
`else
  assign IRQ = 1'b0;
  assign NMI = 1'b0;
`endif

endmodule

// File: tb/tb_sim_sequencer.sv
// tb_sim_sequencer -- directed self-checking bench for sim_sequencer.
//
// There are two instances:
//   u_a: RST_CYCLES=2, RDY_PERIOD=4, RDY_STALL=2, MAX_CYCLES=100,
//        IRQ_AT=10/3, NMI_AT=20/2. Used for the hold sequence, the stall
//        pattern, the interrupt windows, the timeout, and RST from DONE.
//   u_b: AW=13, RST_CYCLES=1, RDY_PERIOD=5, RDY_STALL=3, MAX_CYCLES=51,
//        STOP_ADDR=16'hE123. Used for RST in STALL, the stop/timeout tie,
//        stop versus stall priority, and onend during a stall.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked at
// the same point, once the edge has settled.

module tb_sim_sequencer;

`ifdef SIM_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic        a_rst, a_sync, a_we, a_onend;
  logic [15:0] a_ab;
  logic        a_cpu_rst, a_rdy, a_irq, a_nmi, a_done, a_to;
  logic [31:0] a_cnt;

  logic        b_rst, b_sync, b_we, b_onend;
  logic [12:0] b_ab;
  logic        b_cpu_rst, b_rdy, b_irq, b_nmi, b_done, b_to;
  logic [31:0] b_cnt;

  sim_sequencer #(
    .AW(16), .RST_CYCLES(2), .MAX_CYCLES(100), .RDY_PERIOD(4), .RDY_STALL(2),
    .STOP_ADDR(16'hFFFF), .IRQ_AT(10), .IRQ_LEN(3), .NMI_AT(20), .NMI_LEN(2)
  ) u_a (
    .clk(clk), .RST(a_rst), .sync(a_sync), .AB(a_ab), .WE(a_we), .onend(a_onend),
    .cpu_rst(a_cpu_rst), .RDY(a_rdy), .IRQ(a_irq), .NMI(a_nmi),
    .cycle_cnt(a_cnt), .done(a_done), .timeout(a_to)
  );

  sim_sequencer #(
    .AW(13), .RST_CYCLES(1), .MAX_CYCLES(51), .RDY_PERIOD(5), .RDY_STALL(3),
    .STOP_ADDR(16'hE123), .IRQ_AT(0), .IRQ_LEN(8), .NMI_AT(0), .NMI_LEN(2)
  ) u_b (
    .clk(clk), .RST(b_rst), .sync(b_sync), .AB(b_ab), .WE(b_we), .onend(b_onend),
    .cpu_rst(b_cpu_rst), .RDY(b_rdy), .IRQ(b_irq), .NMI(b_nmi),
    .cycle_cnt(b_cnt), .done(b_done), .timeout(b_to)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both instances held in reset for 3 cycles.
  task automatic test_reset();
    a_rst = 1'b1; a_sync = 1'b0; a_we = 1'b0; a_onend = 1'b0; a_ab = 16'h0000;
    b_rst = 1'b1; b_sync = 1'b0; b_we = 1'b0; b_onend = 1'b0; b_ab = 13'h0000;
    repeat (3) step();
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_a_cpu_rst got %0b exp 1", a_cpu_rst); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_a_rdy got %0b exp 1", a_rdy); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL reset_a_cnt got %0d exp 0", a_cnt); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done got %0b exp 0", a_done); end
    checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL reset_a_timeout got %0b exp 0", a_to); end
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL reset_a_irq got %0b exp 0", a_irq); end
    checks++; if (a_nmi !== 1'b0) begin errors++; $display("FAIL reset_a_nmi got %0b exp 0", a_nmi); end
    checks++; if (b_cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_b_cpu_rst got %0b exp 1", b_cpu_rst); end
    checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL reset_b_rdy got %0b exp 1", b_rdy); end
    checks++; if (b_cnt !== 32'd0) begin errors++; $display("FAIL reset_b_cnt got %0d exp 0", b_cnt); end
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL reset_b_done got %0b exp 0", b_done); end
    checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL reset_b_timeout got %0b exp 0", b_to); end
  endtask

  // RST_CYCLES=2: cpu_rst stays high for two cycles after release, and the count
  // is 0 in the first RUN cycle.
  task automatic test_hold_release();
    a_rst = 1'b0;
    step();
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL hold1_cpu_rst got %0b exp 1", a_cpu_rst); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL hold1_cnt got %0d exp 0", a_cnt); end
    step();
    checks++; if (a_cpu_rst !== 1'b0) begin errors++; $display("FAIL hold2_cpu_rst got %0b exp 0", a_cpu_rst); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL hold2_rdy got %0b exp 1", a_rdy); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL hold2_cnt got %0d exp 0", a_cnt); end
  endtask

  // Period 4, stall 2: RDY is low while cycle_cnt is 4,5 / 10,11 / 16,17 / ...
  // IRQ (when built) is visible while cycle_cnt is 11..13.
  // Stray opcode fetches never hit 16'hFFFF, and WE toggles throughout.
  task automatic test_stalls();
    logic exp_rdy, exp_irq;
    for (int k = 1; k <= 20; k++) begin
      a_we = k[0]; a_sync = 1'b1; a_ab = 16'(k);
      step();
      exp_rdy = !(k >= 4 && ((k - 4) % 6) < 2);
      exp_irq = IRQ_ON && (k >= 11) && (k <= 13);
      checks++; if (a_cnt !== 32'(k)) begin errors++; $display("FAIL stall_cnt k=%0d got %0d exp %0d", k, a_cnt, k); end
      checks++; if (a_rdy !== exp_rdy) begin errors++; $display("FAIL stall_rdy k=%0d got %0b exp %0b", k, a_rdy, exp_rdy); end
      checks++; if (a_irq !== exp_irq) begin errors++; $display("FAIL stall_irq k=%0d got %0b exp %0b", k, a_irq, exp_irq); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL stall_done k=%0d got %0b exp 0", k, a_done); end
    end
  endtask

  // NMI (when built) is visible while cycle_cnt is 21..22. IRQ is over.
  task automatic test_interrupts();
    logic exp_rdy, exp_nmi;
    for (int k = 21; k <= 30; k++) begin
      a_we = k[0]; a_sync = k[1]; a_ab = 16'(k);
      step();
      exp_rdy = !(((k - 4) % 6) < 2);
      exp_nmi = IRQ_ON && (k >= 21) && (k <= 22);
      checks++; if (a_cnt !== 32'(k)) begin errors++; $display("FAIL irq_cnt k=%0d got %0d exp %0d", k, a_cnt, k); end
      checks++; if (a_rdy !== exp_rdy) begin errors++; $display("FAIL irq_rdy k=%0d got %0b exp %0b", k, a_rdy, exp_rdy); end
      checks++; if (a_nmi !== exp_nmi) begin errors++; $display("FAIL irq_nmi k=%0d got %0b exp %0b", k, a_nmi, exp_nmi); end
      checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_irq_off k=%0d got %0b exp 0", k, a_irq); end
    end
  endtask

  // MAX_CYCLES=100, no stop. cycle_cnt 99 would also start a stall, but the
  // timeout takes priority. done and timeout stay high with the count frozen.
  task automatic test_timeout();
    logic exp_rdy;
    for (int k = 31; k <= 99; k++) begin
      a_we = k[0]; a_sync = 1'b1; a_ab = 16'(k);
      step();
      exp_rdy = !(((k - 4) % 6) < 2);
      checks++; if (a_cnt !== 32'(k)) begin errors++; $display("FAIL to_cnt k=%0d got %0d exp %0d", k, a_cnt, k); end
      checks++; if (a_rdy !== exp_rdy) begin errors++; $display("FAIL to_rdy k=%0d got %0b exp %0b", k, a_rdy, exp_rdy); end
    end
    step();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL to_done got %0b exp 1", a_done); end
    checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL to_timeout got %0b exp 1", a_to); end
    checks++; if (a_cnt !== 32'd100) begin errors++; $display("FAIL to_final_cnt got %0d exp 100", a_cnt); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL to_rdy_frozen got %0b exp 0", a_rdy); end
    checks++; if (a_cpu_rst !== 1'b0) begin errors++; $display("FAIL to_cpu_rst got %0b exp 0", a_cpu_rst); end
    // A stop address and onend arriving after DONE must not change anything.
    a_sync = 1'b1; a_ab = 16'hFFFF; a_onend = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step();
      checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sticky_done j=%0d got %0b exp 1", j, a_done); end
      checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL sticky_timeout j=%0d got %0b exp 1", j, a_to); end
      checks++; if (a_cnt !== 32'd100) begin errors++; $display("FAIL sticky_cnt j=%0d got %0d exp 100", j, a_cnt); end
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL sticky_rdy j=%0d got %0b exp 0", j, a_rdy); end
      checks++; if (a_irq !== 1'b0 || a_nmi !== 1'b0) begin errors++; $display("FAIL sticky_int j=%0d got %0b%0b exp 00", j, a_irq, a_nmi); end
    end
    a_onend = 1'b0; a_sync = 1'b0;
  endtask

  // RST from DONE clears everything on the next edge.
  task automatic test_rst_from_done();
    a_rst = 1'b1;
    step();
    checks++; if (a_cpu_rst !== 1'b1) begin errors++; $display("FAIL rstdone_cpu_rst got %0b exp 1", a_cpu_rst); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL rstdone_rdy got %0b exp 1", a_rdy); end
    checks++; if (a_cnt !== 32'd0) begin errors++; $display("FAIL rstdone_cnt got %0d exp 0", a_cnt); end
    checks++; if (a_done !== 1'b0 || a_to !== 1'b0) begin errors++; $display("FAIL rstdone_flags got %0b%0b exp 00", a_done, a_to); end
  endtask

  // u_b: period 5, stall 3, so stalls cover cycle_cnt 5-7, 13-15, ..., 37-39.
  // RST arrives while in STALL at cycle_cnt 37. Near-miss fetches are also
  // driven: sync with a mismatched address, or the stop address without sync.
  task automatic test_rst_in_stall();
    logic exp_rdy;
    b_rst = 1'b0;
    step();
    checks++; if (b_cpu_rst !== 1'b0) begin errors++; $display("FAIL b_release_cpu_rst got %0b exp 0", b_cpu_rst); end
    for (int k = 1; k <= 37; k++) begin
      b_we = ~k[0]; b_sync = k[0]; b_ab = k[0] ? 13'h1123 : 13'h0123;
      step();
      exp_rdy = !(k >= 5 && ((k - 5) % 8) < 3);
      checks++; if (b_cnt !== 32'(k)) begin errors++; $display("FAIL b_cnt k=%0d got %0d exp %0d", k, b_cnt, k); end
      checks++; if (b_rdy !== exp_rdy) begin errors++; $display("FAIL b_rdy k=%0d got %0b exp %0b", k, b_rdy, exp_rdy); end
    end
    b_sync = 1'b0; b_rst = 1'b1;
    step();
    checks++; if (b_cpu_rst !== 1'b1) begin errors++; $display("FAIL stallrst_cpu_rst got %0b exp 1", b_cpu_rst); end
    checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL stallrst_rdy got %0b exp 1", b_rdy); end
    checks++; if (b_cnt !== 32'd0) begin errors++; $display("FAIL stallrst_cnt got %0d exp 0", b_cnt); end
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL stallrst_done got %0b exp 0", b_done); end
    b_rst = 1'b0;
    step();
    checks++; if (b_cpu_rst !== 1'b0) begin errors++; $display("FAIL rerelease_cpu_rst got %0b exp 0", b_cpu_rst); end
    checks++; if (b_cnt !== 32'd0) begin errors++; $display("FAIL rerelease_cnt got %0d exp 0", b_cnt); end
  endtask

  // A fetch of STOP_ADDR low bits at cycle_cnt 50 coincides with the
  // MAX_CYCLES=51 limit. The stop wins, so timeout stays low.
  task automatic test_stop_sync();
    for (int k = 1; k <= 50; k++) begin
      b_sync = k[0]; b_ab = 13'h1123;
      step();
      checks++; if (b_cnt !== 32'(k)) begin errors++; $display("FAIL stop_run_cnt k=%0d got %0d exp %0d", k, b_cnt, k); end
    end
    b_sync = 1'b1; b_ab = 13'h0123;
    step();
    b_sync = 1'b0;
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL stop_done got %0b exp 1", b_done); end
    checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL stop_timeout got %0b exp 0", b_to); end
    checks++; if (b_cnt !== 32'd51) begin errors++; $display("FAIL stop_cnt got %0d exp 51", b_cnt); end
    checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL stop_rdy got %0b exp 0", b_rdy); end
    checks++; if (b_cpu_rst !== 1'b0) begin errors++; $display("FAIL stop_cpu_rst got %0b exp 0", b_cpu_rst); end
    repeat (5) step();
    checks++; if (b_cnt !== 32'd51 || b_done !== 1'b1) begin errors++; $display("FAIL stop_frozen got cnt %0d done %0b exp 51 1", b_cnt, b_done); end
  endtask

  // At cycle_cnt 4 a stall would start, but onend on the same cycle takes
  // priority.
  task automatic test_stop_precedence();
    b_rst = 1'b1; step(); b_rst = 1'b0; step();
    for (int k = 1; k <= 4; k++) step();
    b_onend = 1'b1;
    step();
    b_onend = 1'b0;
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL prec_done got %0b exp 1", b_done); end
    checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL prec_timeout got %0b exp 0", b_to); end
    checks++; if (b_cnt !== 32'd5) begin errors++; $display("FAIL prec_cnt got %0d exp 5", b_cnt); end
  endtask

  // onend while stalled (cycle_cnt 6) also ends the run.
  task automatic test_onend_in_stall();
    b_rst = 1'b1; step(); b_rst = 1'b0; step();
    for (int k = 1; k <= 6; k++) step();
    checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL onst_in_stall got %0b exp 0", b_rdy); end
    b_onend = 1'b1;
    step();
    b_onend = 1'b0;
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL onst_done got %0b exp 1", b_done); end
    checks++; if (b_to !== 1'b0) begin errors++; $display("FAIL onst_timeout got %0b exp 0", b_to); end
    checks++; if (b_cnt !== 32'd7) begin errors++; $display("FAIL onst_cnt got %0d exp 7", b_cnt); end
    checks++; if (b_irq !== 1'b0 || b_nmi !== 1'b0) begin errors++; $display("FAIL onst_int got %0b%0b exp 00", b_irq, b_nmi); end
  endtask

  initial begin
    test_reset();
    test_hold_release();
    test_stalls();
    test_interrupts();
    test_timeout();
    test_rst_from_done();
    test_rst_in_stall();
    test_stop_sync();
    test_stop_precedence();
    test_onend_in_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
